mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the on-chip memory controller.
- Port 0 serves instruction fetch; port 1 serves load/store.
- Serialises requests into single-cycle read/write strobes and waits for the controller's read ack (2 cycles after the strobe) or same-cycle write ack.
- Returns a one-cycle ack plus read data or an error to the granted requester. Unacked accesses (DRAM half of the address space) are terminated by timeout.

Parameters:
ADDR_BITS, `MEM_ADDR_BITS, width of memory word address
XLEN, `XLEN (32), data width; byte-enable width XLEN/8
TIMEOUT_CYCLES, 15, cycles in RD_WAIT before an unacked read is aborted with error (legal 3..255)
FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 1 always wins on contention

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sync_reset  in  1  synchronous flush to IDLE, active-high
- pN_addr  in  ADDR_BITS  requester N address (N = 0,1), held until pN_ack
- pN_read  in  1  requester N read request, level, held until pN_ack
- pN_write_en  in  XLEN/8  requester N byte write enables, non-zero = write request, held until pN_ack
- pN_write_data  in  XLEN  requester N write data
- pN_ack  out  1  one-cycle completion pulse to requester N
- pN_err  out  1  with pN_ack: access not acknowledged by memory
- pN_read_data  out  XLEN  read data, valid in pN_ack cycle, shared register for both ports
- mem_addr  out  ADDR_BITS  to controller
- mem_read_en  out  1  to controller
- mem_write_en  out  XLEN/8  to controller
- mem_write_data  out  XLEN  to controller
- mem_read_data  in  XLEN  from controller, valid with mem_read_ack
- mem_write_ack  in  1  combinational, same cycle as mem_write_en
- mem_read_ack  in  1  2 cycles after mem_read_en

Behaviour:
- Reset/sync_reset:
  - Every output is 0.
  - state = IDLE, last_grant = 1 (port 0 wins first contention), timeout counter = 0.
  - sync_reset takes effect at the next edge and overrides all other transitions.
- All outputs are registered or decoded from state plus registers. No combinational path from pN_* to mem_* or from mem_* acks to pN_ack.
- Request is pending on port N when pN_read | (|pN_write_en). If both are set, the write wins and the read is ignored.
- IDLE:
  - If any request is pending: grant one port, latch its addr/we/data/read into issue registers, update last_grant, go to ISSUE.
  - Contention: FIXED_PRIORITY=1 grants port 1; otherwise grant the port != last_grant.
- ISSUE (exactly 1 cycle): drive mem_addr/mem_write_data from the issue registers, and pulse mem_read_en or mem_write_en.
  - Write with mem_write_ack=1: go to DONE, err=0.
  - Write with mem_write_ack=0: go to DONE, err=1.
  - Read: clear counter, go to RD_WAIT.
- RD_WAIT: mem_* strobes = 0.
  - mem_read_ack=1: capture mem_read_data into pN_read_data, err=0, go to DONE.
  - Else counter++. When counter reaches TIMEOUT_CYCLES: pN_read_data = 0, err=1, go to DONE.
- DONE (1 cycle): assert pN_ack (and pN_err if set) for the granted port only, go to IDLE.
  - The requester drops its request at the end of this cycle, so IDLE in the next cycle never re-grants a stale request.
- Latency, request first seen in IDLE at cycle 0:
  - Write: strobe cycle 1, ack cycle 2.
  - Read: strobe cycle 1, mem_read_ack cycle 3, pN_ack cycle 4.
  - Back-to-back throughput: one write per 3 cycles, one read per 5 cycles.
- Stray mem_read_ack outside RD_WAIT (e.g. after sync_reset mid-read or after a timeout) is ignored.
- pN_read_data holds its value until the next read completion. It is not cleared on write completion.
- Asynchronous reset mid-access: drop everything immediately; the in-flight requester receives no ack.
- Requester changing addr/data while pending is outside contract; the values latched in IDLE are used.

Decomposition:
- Shared include (config.vh/common.vh): ADDR/XLEN widths, state encoding localparams (IDLE, ISSUE, RD_WAIT, DONE), default TIMEOUT_CYCLES.
- Sub-module: arb_rr2, the two-way round-robin/fixed-priority grant logic with last_grant register. Everything else stays in mem_arbiter.

Test Plan:
- Port 0 read addr 0x0010 (SRAM preloaded 0x12345678) -> mem_read_en pulse at cycle 1; p0_ack=1, p0_read_data=0x12345678, p0_err=0 at cycle 4; p1_ack stays 0.
- Port 1 write 0xCAFEF00D, we=4'b0011, addr 0x0020, then read back -> p1_ack at cycle 2 with err=0; readback returns 0x0000F00D over prior zero contents.
- Both ports request reads in the same cycle after reset, held continuously -> grants alternate 0,1,0,1. With FIXED_PRIORITY=1, port 1 is served every time and port 0 starves.
- Read at address with top bit set (DRAM half), TIMEOUT_CYCLES=15 -> no mem_read_ack; p0_ack with p0_err=1 and read_data=0 exactly 15 cycles after entering RD_WAIT. Write to the same address -> ack with err=1 at cycle 2.
- sync_reset asserted in RD_WAIT one cycle before mem_read_ack -> FSM in IDLE, late ack ignored, no pN_ack pulse; the next request completes normally.
- Async reset pulse mid-write -> all outputs 0 immediately; after release, first contention goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, defaults and FSM encoding for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_BITS = 16;
   localparam int unsigned XLEN_BITS     = 32;
   localparam int unsigned DEF_TIMEOUT   = 15;
   localparam int unsigned CNT_BITS      = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way grant selection with a last-grant register (round-robin or port-1 priority).
module mem_arbiter_arb_rr2 #(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sync_reset_i,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       gnt_c_o,
   output logic       last_o
);

   logic last_q, last_d;

   // Contention goes to the port that was not granted last, unless port 1 has priority.
   always_comb begin
      if (&req_i) begin
         gnt_c_o = FIXED_PRIORITY ? 1'b1 : ~last_q;
      end else begin
         gnt_c_o = req_i[1];
      end
      last_d = last_q;
      if (take_i) begin
         last_d = gnt_c_o;
      end
      if (sync_reset_i) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer: serialises fetch and load/store accesses into
// single-cycle memory strobes and returns a one-cycle ack (with error on timeout).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_BITS      = MEM_ADDR_BITS,
   parameter int unsigned XLEN           = XLEN_BITS,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int unsigned FIXED_PRIORITY = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sync_reset,
   input  logic [ADDR_BITS-1:0] p0_addr,
   input  logic                 p0_read,
   input  logic [XLEN/8-1:0]    p0_write_en,
   input  logic [XLEN-1:0]      p0_write_data,
   output logic                 p0_ack,
   output logic                 p0_err,
   output logic [XLEN-1:0]      p0_read_data,
   input  logic [ADDR_BITS-1:0] p1_addr,
   input  logic                 p1_read,
   input  logic [XLEN/8-1:0]    p1_write_en,
   input  logic [XLEN-1:0]      p1_write_data,
   output logic                 p1_ack,
   output logic                 p1_err,
   output logic [XLEN-1:0]      p1_read_data,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_read_en,
   output logic [XLEN/8-1:0]    mem_write_en,
   output logic [XLEN-1:0]      mem_write_data,
   input  logic [XLEN-1:0]      mem_read_data,
   input  logic                 mem_write_ack,
   input  logic                 mem_read_ack
);

   localparam int unsigned BE = XLEN / 8;
   localparam int unsigned CW = CNT_BITS;

   arb_state_e           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 rd_en_q, rd_en_d;
   logic [BE-1:0]        we_q, we_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic [XLEN-1:0]      rdata_q, rdata_d;
   logic [1:0]           ack_q, ack_d;
   logic [1:0]           err_q, err_d;

   logic [1:0]           pend_c;
   logic                 gnt_c, last_q, take_c;
   logic [ADDR_BITS-1:0] sel_addr_c;
   logic                 sel_rd_c;
   logic [BE-1:0]        sel_we_c;
   logic [XLEN-1:0]      sel_wdata_c;

   assign pend_c = {p1_read | (|p1_write_en), p0_read | (|p0_write_en)};

   mem_arbiter_arb_rr2 #(
      .FIXED_PRIORITY(FIXED_PRIORITY != 0)
   ) u_arb (
      .clk          (clk),
      .reset        (reset),
      .sync_reset_i (sync_reset),
      .req_i        (pend_c),
      .take_i       (take_c),
      .gnt_c_o      (gnt_c),
      .last_o       (last_q)
   );

   assign sel_addr_c  = gnt_c ? p1_addr       : p0_addr;
   assign sel_rd_c    = gnt_c ? p1_read       : p0_read;
   assign sel_we_c    = gnt_c ? p1_write_en   : p0_write_en;
   assign sel_wdata_c = gnt_c ? p1_write_data : p0_write_data;

   // last_q names the granted port from ISSUE through DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_en_d = 1'b0;
      we_d    = '0;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = '0;
      err_d   = '0;
      take_c  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (|pend_c) begin
               take_c  = 1'b1;
               addr_d  = sel_addr_c;
               we_d    = sel_we_c;
               wdata_d = sel_wdata_c;
               rd_en_d = sel_rd_c & ~(|sel_we_c);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rd_en_q) begin
               cnt_d   = '0;
               state_d = ST_RD_WAIT;
            end else begin
               ack_d[last_q] = 1'b1;
               err_d[last_q] = ~mem_write_ack;
               state_d       = ST_DONE;
            end
         end
         ST_RD_WAIT: begin
            if (mem_read_ack) begin
               rdata_d       = mem_read_data;
               ack_d[last_q] = 1'b1;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                  rdata_d       = '0;
                  ack_d[last_q] = 1'b1;
                  err_d[last_q] = 1'b1;
                  state_d       = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (sync_reset) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         addr_d  = '0;
         rd_en_d = 1'b0;
         we_d    = '0;
         wdata_d = '0;
         rdata_d = '0;
         ack_d   = '0;
         err_d   = '0;
         take_c  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         we_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_en_q <= rd_en_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr       = addr_q;
   assign mem_read_en    = rd_en_q;
   assign mem_write_en   = we_q;
   assign mem_write_data = wdata_q;
   assign p0_ack         = ack_q[0];
   assign p1_ack         = ack_q[1];
   assign p0_err         = err_q[0];
   assign p1_err         = err_q[1];
   assign p0_read_data   = rdata_q;
   assign p1_read_data   = rdata_q;

endmodule
